// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC array output path.
package mac_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int ROWS   = 4;

  localparam logic [LANE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [LANE_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} ostate_t;

  // One result row: lane i sits in bits [16i+15:16i]
  typedef logic [LANES-1:0][LANE_W-1:0] row_t;

endpackage

// File: rtl/output_stage_sat_add_lanes.sv
// Lane-wise signed saturating adder over one result row.
// Purely combinational: no latency, no flow control.
module sat_add_lanes
  import mac_pkg::*;
(
  input  row_t a,
  input  row_t b,
  output row_t y
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W:0] sum;

    assign sum = {a[i][LANE_W-1], a[i]} + {b[i][LANE_W-1], b[i]};
    // Top two bits disagree only on overflow; the 17th bit gives the true sign
    assign y[i] = (sum[LANE_W] != sum[LANE_W-1]) ? (sum[LANE_W] ? SAT_MIN : SAT_MAX)
                                                 : sum[LANE_W-1:0];
  end

endmodule

// File: rtl/output_stage.sv
// Tile-pass receiver: captures four MAC rows per pass, accumulates them across depth passes,
// writes the tile out on the final pass (holding each write while OREADY is low) and pulses Tile_Done.
module output_stage
  import mac_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    START_CALC,
  input  logic                    FIRST,
  input  logic                    LAST,
  input  logic [3:0]              ODST,
  input  logic                    MAC_VLD,
  input  logic [LANES*LANE_W-1:0] MAC_DATA,
  input  logic                    OREADY,
  output logic                    OWE,
  output logic [5:0]              OADDR,
  output logic [LANES*LANE_W-1:0] ODATA,
  output logic                    Tile_Done,
  output logic                    BUSY,
  output logic                    ERR
);

  ostate_t    state_q, state_d;
  logic       first_q, last_q;
  logic [3:0] tile_q;
  logic [1:0] rc, wc;
  logic       err_q;
  row_t       buf_q [ROWS];
  row_t       acc_base, acc_sum;
  logic       accept, wr_acc, proto_err;

  assign accept    = (state_q == CAPTURE) && START_CALC && MAC_VLD;
  assign wr_acc    = (state_q == WRITE) && OREADY;
  assign proto_err = (MAC_VLD && (state_q != CAPTURE)) || ((state_q == CAPTURE) && !START_CALC);

  // A FIRST pass adds onto zero, so one adder serves both overwrite and accumulate
  assign acc_base = first_q ? '0 : buf_q[rc];

  sat_add_lanes u_sat (
    .a (acc_base),
    .b (MAC_DATA),
    .y (acc_sum)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START_CALC) state_d = CAPTURE;
      CAPTURE: begin
        if (!START_CALC)                  state_d = IDLE;
        else if (MAC_VLD && rc == 2'd3)   state_d = last_q ? WRITE : DONE;
      end
      WRITE:   if (OREADY && wc == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
      tile_q  <= '0;
      rc      <= '0;
      wc      <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) buf_q[r] <= '0;
    end else begin
      if (state_q == IDLE && START_CALC) begin
        first_q <= FIRST;
        last_q  <= LAST;
        tile_q  <= ODST;
        rc      <= '0;
        wc      <= '0;
      end
      if (accept) begin
        buf_q[rc] <= acc_sum;
        rc        <= rc + 2'd1;
      end
      if (wr_acc)    wc    <= wc + 2'd1;
      if (proto_err) err_q <= 1'b1;
    end
  end

  // Outputs decode registered state only; address and data read as zero outside WRITE
  always_comb begin
    OWE       = 1'b0;
    OADDR     = '0;
    ODATA     = '0;
    Tile_Done = (state_q == DONE);
    BUSY      = (state_q != IDLE);
    ERR       = err_q;
    if (state_q == WRITE) begin
      OWE   = 1'b1;
      OADDR = {tile_q, wc};
      ODATA = buf_q[wc];
    end
  end

endmodule
